msrv32_ifetch_unit: RTL and testbench
=====================================

// Module: msrv32_ifetch_unit
// PURPOSE
//  Instruction-fetch stage directly downstream of the PC mux. Holds the architectural PC, issues fetch requests on the
//  instruction bus, and buffers returned words (2-entry FIFO) for decode. Feeds pc_out back to the PC mux as its
//  current PC and consumes pc_mux_in as the next PC. Handles flush/redirect, decode back-pressure and misaligned-PC faults.
// PARAMETERS
//  BOOT_ADDR  32'h0000_0000  PC loaded on reset
//  NOP_INSTR  32'h0000_0013  value driven on instr_out when no valid word is held (addi x0,x0,0)
// PORTS
//  clk_in            in   1   clock, all state updates on rising edge
//  rst_n_in          in   1   synchronous reset, active-low
//  pc_mux_in         in   32  next PC selected by the PC mux
//  flush_in          in   1   redirect: discard buffered/returning words, load pc_mux_in
//  stall_in          in   1   decode cannot accept the head word this cycle
//  ahb_ready_in      in   1   bus ready; when high with i_req_out, instr_in is valid this cycle
//  instr_in          in   32  fetched instruction word
//  i_req_out         out  1   fetch request
//  i_addr_out        out  32  fetch address (= pc_reg)
//  pc_out            out  32  current PC (pc_reg), to PC mux pc_in
//  instr_valid_out   out  1   head of buffer valid for decode
//  instr_out         out  32  head instruction word (NOP_INSTR when not valid)
//  instr_pc_out      out  32  PC of the head word
//  misaligned_out    out  1   fault: pc_reg[1:0]!=0, held until flush_in
// BEHAVIOUR
//  - Reset (rst_n_in=0 at edge): pc_reg=BOOT_ADDR, state=RST, count=0, i_req_out=0, instr_valid_out=0,
//    instr_out=NOP_INSTR, instr_pc_out=BOOT_ADDR, misaligned_out=0. Reset mid-transfer aborts; no word is kept.
//  - States: RST -> FETCH (unconditional, 1 cycle after reset release). FETCH -> HOLD when count==2 after update.
//    HOLD -> FETCH when count<2. FETCH/HOLD -> FAULT when pc_reg[1:0]!=0. FAULT -> FETCH only on flush_in.
//  - i_req_out = (state==FETCH) & (count<2) & (pc_reg[1:0]==0); combinational from registered state. Address = pc_reg.
//  - Handshake: accept = i_req_out & ahb_ready_in & ~flush_in. On accept: push {instr_in, pc_reg}, pc_reg<=pc_mux_in.
//    No accept -> pc_reg and request held stable (address must not change while waiting).
//  - Pop = instr_valid_out & ~stall_in. Push and pop in the same cycle with count==2 is not possible (no request);
//    push+pop with count==1 keeps count==1. Single-cycle fetch sustains 1 word/cycle with stall_in=0.
//  - Latency: word accepted at edge N is on instr_out after edge N if buffer was empty (no bypass of instr_in).
//  - flush_in (priority over stall_in, ahb_ready_in, fault): count<=0, pc_reg<=pc_mux_in, misaligned_out<=0,
//    state<=FETCH; word returned in the same cycle is dropped. Flush during RST is ignored.
//  - FAULT: on entry misaligned_out<=1, i_req_out=0; buffered words still drain to decode; state held until flush.
//  - Width: all PCs 32-bit, no carry out; BOOT_ADDR must be word-aligned. count is 2 bits, range 0..2.
//  - instr_out/instr_pc_out driven from buffer head; instr_out=NOP_INSTR whenever count==0.
// TESTING
//  1 Reset: rst_n_in=0 2 cycles, release -> pc_out=0, i_req_out=0 one cycle then 1, i_addr_out=0, instr_valid_out=0.
//  2 Streaming: ahb_ready_in=1, pc_mux_in=pc_out+4, instr_in=addr-tagged -> words 0x0,0x4,0x8 valid on consecutive
//    cycles, instr_pc_out matching, one cycle after each accept.
//  3 Back-pressure: stall_in=1 from first valid -> 2 words buffered, i_req_out=0, pc_out=0x8 held; release stall ->
//    words 0x0,0x4 popped in order, fetch resumes at 0x8.
//  4 Wait states: ahb_ready_in=0 for 3 cycles at 0x4 -> i_addr_out stays 0x4, no valid output, pc_out unchanged.
//  5 Flush: flush_in=1 with ahb_ready_in=1, count=1, pc_mux_in=0x100 -> next cycle count=0, instr_valid_out=0,
//    returned word dropped, i_addr_out=0x100.
//  6 Fault: flush to pc_mux_in=0x102 -> misaligned_out=1 next cycle, i_req_out=0 until flush to 0x200 clears it.

Source files
------------

// File: rtl/msrv32_ifetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : msrv32_ifetch_unit
//  Description : Instruction-fetch stage. Holds the architectural PC, issues
//                fetch requests on the instruction bus and buffers returned
//                words in a 2-entry FIFO for decode. Handles redirect (flush),
//                decode back-pressure (stall) and misaligned-PC faults.
//  Ports       : clk_in, rst_n_in (sync, active-low)
//                pc_mux_in        next PC from the PC mux
//                flush_in         redirect, discards buffered/returning words
//                stall_in         decode cannot take the head word
//                ahb_ready_in     bus ready, instr_in valid with i_req_out
//                instr_in         fetched word
//                i_req_out/i_addr_out  fetch request and address
//                pc_out           current PC back to the PC mux
//                instr_valid_out/instr_out/instr_pc_out  buffer head to decode
//                misaligned_out   sticky fault until next flush
//  Revision    : 1.0 - initial release
// ============================================================================
module msrv32_ifetch_unit #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [31:0] pc_mux_in,
    input  logic        flush_in,
    input  logic        stall_in,
    input  logic        ahb_ready_in,
    input  logic [31:0] instr_in,
    output logic        i_req_out,
    output logic [31:0] i_addr_out,
    output logic [31:0] pc_out,
    output logic        instr_valid_out,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc_out,
    output logic        misaligned_out
);

    typedef enum logic [1:0] {
        S_RST   = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [1:0]  r_count;
    logic [1:0]  w_count_next;
    logic [31:0] r_instr0, r_instr1;   // entry 0 is the buffer head
    logic [31:0] r_pc0, r_pc1;
    logic        r_misaligned;

    logic        w_pc_misaligned;
    logic        w_accept;
    logic        w_pop;

    assign w_pc_misaligned = (r_pc[1:0] != 2'b00);

    // Request is blocked by a full buffer or a misaligned PC even before the
    // state machine has moved to HOLD/FAULT.
    assign i_req_out       = (r_state == S_FETCH) && (r_count < 2'd2) && !w_pc_misaligned;
    assign i_addr_out      = r_pc;
    assign pc_out          = r_pc;
    assign w_accept        = i_req_out && ahb_ready_in && !flush_in;
    assign instr_valid_out = (r_count != 2'd0);
    assign w_pop           = instr_valid_out && !stall_in;
    assign instr_out       = instr_valid_out ? r_instr0 : NOP_INSTR;
    assign instr_pc_out    = r_pc0;
    assign misaligned_out  = r_misaligned;

    always_comb begin
        w_count_next = r_count;
        if (flush_in) begin
            w_count_next = 2'd0;
        end else if (w_accept && !w_pop) begin
            w_count_next = r_count + 2'd1;
        end else if (!w_accept && w_pop) begin
            w_count_next = r_count - 2'd1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RST: begin
                w_state_next = S_FETCH;
            end
            S_FETCH, S_HOLD: begin
                if (flush_in) begin
                    w_state_next = S_FETCH;
                end else if (w_pc_misaligned) begin
                    w_state_next = S_FAULT;
                end else if (w_count_next == 2'd2) begin
                    w_state_next = S_HOLD;
                end else begin
                    w_state_next = S_FETCH;
                end
            end
            S_FAULT: begin
                if (flush_in) begin
                    w_state_next = S_FETCH;
                end
            end
            default: begin
                w_state_next = S_RST;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state      <= S_RST;
            r_pc         <= BOOT_ADDR;
            r_count      <= 2'd0;
            r_instr0     <= NOP_INSTR;
            r_instr1     <= NOP_INSTR;
            r_pc0        <= BOOT_ADDR;
            r_pc1        <= BOOT_ADDR;
            r_misaligned <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // Nothing but the state moves while leaving reset, so a flush
            // arriving in that cycle is ignored.
            if (r_state != S_RST) begin
                r_count <= w_count_next;
                if (flush_in) begin
                    r_pc         <= pc_mux_in;
                    r_misaligned <= 1'b0;
                end else begin
                    if (w_accept) begin
                        r_pc <= pc_mux_in;
                    end
                    if (w_state_next == S_FAULT) begin
                        r_misaligned <= 1'b1;
                    end
                    if (w_pop) begin
                        r_instr0 <= r_instr1;
                        r_pc0    <= r_pc1;
                    end
                    // Writing entry 0 after the shift lets a push into an
                    // emptying head win over the stale shifted value.
                    if (w_accept) begin
                        if ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop)) begin
                            r_instr0 <= instr_in;
                            r_pc0    <= r_pc;
                        end else begin
                            r_instr1 <= instr_in;
                            r_pc1    <= r_pc;
                        end
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_msrv32_ifetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_msrv32_ifetch_unit
//  Description : Directed testbench for msrv32_ifetch_unit. Returned words are
//                tagged with their fetch address (addr ^ 32'hDEAD_0000).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_msrv32_ifetch_unit;

    logic        clk_in;
    logic        rst_n_in;
    logic [31:0] pc_mux_in;
    logic        flush_in;
    logic        stall_in;
    logic        ahb_ready_in;
    logic [31:0] instr_in;
    logic        i_req_out;
    logic [31:0] i_addr_out;
    logic [31:0] pc_out;
    logic        instr_valid_out;
    logic [31:0] instr_out;
    logic [31:0] instr_pc_out;
    logic        misaligned_out;

    logic        r_sel;
    logic [31:0] r_force;
    int          n_checks;
    int          n_errors;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    msrv32_ifetch_unit u_dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .pc_mux_in       (pc_mux_in),
        .flush_in        (flush_in),
        .stall_in        (stall_in),
        .ahb_ready_in    (ahb_ready_in),
        .instr_in        (instr_in),
        .i_req_out       (i_req_out),
        .i_addr_out      (i_addr_out),
        .pc_out          (pc_out),
        .instr_valid_out (instr_valid_out),
        .instr_out       (instr_out),
        .instr_pc_out    (instr_pc_out),
        .misaligned_out  (misaligned_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    assign pc_mux_in = r_sel ? r_force : (pc_out + 32'd4);
    assign instr_in  = i_addr_out ^ 32'hDEAD_0000;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reset for two edges, release, then one more edge (RST -> FETCH).
    task automatic do_reset();
        rst_n_in     = 1'b0;
        ahb_ready_in = 1'b0;
        stall_in     = 1'b0;
        flush_in     = 1'b0;
        r_sel        = 1'b0;
        step();
        step();
        rst_n_in = 1'b1;
        step();
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst_n_in     = 1'b0;
        flush_in     = 1'b0;
        stall_in     = 1'b0;
        ahb_ready_in = 1'b0;
        r_sel        = 1'b0;
        r_force      = 32'h0;

        // Reset
        step();
        step();
        chk("rst_pc",    pc_out,          32'h0);
        chk("rst_req",   {31'b0, i_req_out},       32'h0);
        chk("rst_valid", {31'b0, instr_valid_out}, 32'h0);
        chk("rst_instr", instr_out,       c_NOP);
        chk("rst_ipc",   instr_pc_out,    32'h0);
        chk("rst_mis",   {31'b0, misaligned_out},  32'h0);
        rst_n_in = 1'b1;
        step();
        chk("req_rise",  {31'b0, i_req_out},       32'h1);
        chk("addr0",     i_addr_out,      32'h0);

        // Streaming
        ahb_ready_in = 1'b1;
        step();
        chk("s0_valid",  {31'b0, instr_valid_out}, 32'h1);
        chk("s0_instr",  instr_out,       32'hDEAD_0000);
        chk("s0_ipc",    instr_pc_out,    32'h0);
        chk("s0_pc",     pc_out,          32'h4);
        step();
        chk("s1_valid",  {31'b0, instr_valid_out}, 32'h1);
        chk("s1_instr",  instr_out,       32'hDEAD_0004);
        chk("s1_ipc",    instr_pc_out,    32'h4);
        step();
        chk("s2_instr",  instr_out,       32'hDEAD_0008);
        chk("s2_ipc",    instr_pc_out,    32'h8);

        // Back-pressure
        do_reset();
        ahb_ready_in = 1'b1;
        step();
        chk("bp_first",  instr_pc_out,    32'h0);
        stall_in = 1'b1;
        step();
        chk("bp_req0",   {31'b0, i_req_out},       32'h0);
        chk("bp_pc8",    pc_out,          32'h8);
        chk("bp_head",   instr_pc_out,    32'h0);
        step();
        chk("bp_req0b",  {31'b0, i_req_out},       32'h0);
        chk("bp_pc8b",   pc_out,          32'h8);
        chk("bp_instr",  instr_out,       32'hDEAD_0000);
        stall_in = 1'b0;
        step();
        chk("bp_pop4",   instr_pc_out,    32'h4);
        chk("bp_ins4",   instr_out,       32'hDEAD_0004);
        chk("bp_resume", {31'b0, i_req_out},       32'h1);
        chk("bp_addr8",  i_addr_out,      32'h8);
        step();
        chk("bp_pop8",   instr_pc_out,    32'h8);
        chk("bp_ins8",   instr_out,       32'hDEAD_0008);

        // Wait states
        do_reset();
        ahb_ready_in = 1'b1;
        step();
        chk("ws_pc4",    pc_out,          32'h4);
        ahb_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ws_addr",  i_addr_out,      32'h4);
            chk("ws_valid", {31'b0, instr_valid_out}, 32'h0);
            chk("ws_pc",    pc_out,          32'h4);
        end
        ahb_ready_in = 1'b1;
        step();
        chk("ws_instr",  instr_out,       32'hDEAD_0004);
        chk("ws_ipc",    instr_pc_out,    32'h4);

        // Flush with one word buffered and a word returning
        flush_in = 1'b1;
        r_sel    = 1'b1;
        r_force  = 32'h100;
        step();
        chk("fl_valid",  {31'b0, instr_valid_out}, 32'h0);
        chk("fl_nop",    instr_out,       c_NOP);
        chk("fl_addr",   i_addr_out,      32'h100);
        chk("fl_req",    {31'b0, i_req_out},       32'h1);
        flush_in = 1'b0;
        r_sel    = 1'b0;
        step();
        chk("fl_new",    instr_out,       32'hDEAD_0100);
        chk("fl_newpc",  instr_pc_out,    32'h100);

        // Misaligned fault
        flush_in = 1'b1;
        r_sel    = 1'b1;
        r_force  = 32'h102;
        step();
        chk("ft_req0",   {31'b0, i_req_out},       32'h0);
        chk("ft_pc",     pc_out,          32'h102);
        flush_in = 1'b0;
        step();
        chk("ft_mis",    {31'b0, misaligned_out},  32'h1);
        chk("ft_req1",   {31'b0, i_req_out},       32'h0);
        step();
        chk("ft_hold",   {31'b0, misaligned_out},  32'h1);
        chk("ft_req2",   {31'b0, i_req_out},       32'h0);
        flush_in = 1'b1;
        r_force  = 32'h200;
        step();
        chk("ft_clear",  {31'b0, misaligned_out},  32'h0);
        chk("ft_reqon",  {31'b0, i_req_out},       32'h1);
        chk("ft_addr",   i_addr_out,      32'h200);
        flush_in = 1'b0;
        r_sel    = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
